// File: rtl/uart_clk_div_pkg.sv
// Shared UART clock-path constants: ratio width, bypass codes and the
// prescale-to-ratio mapping so the ratio source and the divider agree.
package uart_clk_div_pkg;

    localparam int RATIO_WIDTH_DEF = 8;

    localparam int RATIO_BYPASS0 = 0;
    localparam int RATIO_BYPASS1 = 1;

    localparam logic [7:0] RATIO_P32 = 8'd1;
    localparam logic [7:0] RATIO_P16 = 8'd2;
    localparam logic [7:0] RATIO_P8  = 8'd4;
    localparam logic [7:0] RATIO_P4  = 8'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

    // Unsupported prescale values map to bypass.
    function automatic logic [7:0] prescale_to_ratio(input logic [5:0] prescale);
        case (prescale)
            6'd32:   return RATIO_P32;
            6'd16:   return RATIO_P16;
            6'd8:    return RATIO_P8;
            6'd4:    return RATIO_P4;
            default: return 8'(RATIO_BYPASS0);
        endcase
    endfunction

endpackage

// File: rtl/uart_clk_div_if.sv
// Ratio/enable request and divided-clock outputs of the UART TX clock divider.
interface uart_clk_div_if #(
    parameter int RATIO_WIDTH = 8
);

    logic                   clk_en;
    logic [RATIO_WIDTH-1:0] DIV_Ratio;
    logic                   div_clk;
    logic                   div_tick;

    modport master (
        output clk_en,
        output DIV_Ratio,
        input  div_clk,
        input  div_tick
    );

    modport slave (
        input  clk_en,
        input  DIV_Ratio,
        output div_clk,
        output div_tick
    );

endinterface

// File: rtl/uart_clk_div.sv
// Integer clock divider: produces the TX bit-rate clock from CLK using a ratio
// latched only at period boundaries, plus a same-domain start-of-period tick.
module uart_clk_div
    import uart_clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    uart_clk_div_if.slave bus
);

    div_state_e             state, state_n;
    logic [RATIO_WIDTH-1:0] cnt, cnt_n;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_n;
    logic                   div_q, div_n;

    logic                   running;
    logic                   ratio_ok;
    logic                   last;
    logic [RATIO_WIDTH-1:0] half;
    logic [RATIO_WIDTH-1:0] cnt_inc;

    assign running  = (state == ST_RUN);
    assign ratio_ok = (bus.DIV_Ratio != RATIO_WIDTH'(RATIO_BYPASS0)) &&
                      (bus.DIV_Ratio != RATIO_WIDTH'(RATIO_BYPASS1));
    assign half     = ratio_q >> 1;
    assign cnt_inc  = cnt + RATIO_WIDTH'(1);
    // ratio_q >= 2 whenever running, so ratio_q-1 cannot wrap.
    assign last     = (cnt == ratio_q - RATIO_WIDTH'(1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ratio_q <= '0;
            div_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ratio_q <= ratio_n;
            div_q   <= div_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ratio_n = ratio_q;
        div_n   = div_q;
        case (state)
            ST_IDLE: begin
                if (bus.clk_en && ratio_ok) begin
                    state_n = ST_RUN;
                    ratio_n = bus.DIV_Ratio;
                    cnt_n   = '0;
                    div_n   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.clk_en) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    div_n   = 1'b0;
                end else if (last) begin
                    // New ratio is only accepted here, so periods are never cut short.
                    if (ratio_ok) begin
                        ratio_n = bus.DIV_Ratio;
                        cnt_n   = '0;
                        div_n   = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        div_n   = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_inc;
                    div_n = (cnt_inc < half);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                div_n   = 1'b0;
            end
        endcase
    end

    // Bypass passes the reference clock straight through.
    assign bus.div_clk  = running ? div_q : CLK;
    assign bus.div_tick = running && (cnt == '0);

endmodule
